// File: rtl/output_display_driver.sv
// output_display_driver
// Captures a WIDTH-bit value on a load strobe, converts it to BCD with a
// sequential shift-add-3 engine and drives DIGITS active-low seven-segment
// digits with leading-zero blanking and an all-minus overflow indication.
// A one-deep pending buffer keeps the most recent value loaded while busy.
// Optional build macro: DISPLAY_SIGNED_EN (two's complement input with a
// leading minus sign; adds one magnitude cycle before conversion).
module output_display_driver #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      data_in,
  output logic                  busy,
  output logic                  update,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   hex_out
);

  localparam int BCD_DIGITS = 10;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int CW         = $clog2(WIDTH + 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

`ifdef DISPLAY_SIGNED_EN
  typedef enum logic [1:0] {IDLE, NEGATE, CONVERT, COMMIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
`endif

  // Active-low gfedcba pattern for one decimal digit.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Display of the value 0: digit 0 shows "0", every other digit blank.
  function automatic logic [7*DIGITS-1:0] reset_hex();
    logic [7*DIGITS-1:0] r;
    for (int k = 0; k < DIGITS; k++) begin
      r[7*k +: 7] = (k == 0) ? SEG_ZERO : SEG_BLANK;
    end
    return r;
  endfunction

  localparam logic [7*DIGITS-1:0] HEX_RESET = reset_hex();

  state_t                state_reg, state_next;
  logic [WIDTH-1:0]      shift_reg, shift_next;
  logic [BCD_W-1:0]      bcd_reg, bcd_next;
  logic [CW-1:0]         count_reg, count_next;
  logic [WIDTH-1:0]      pending_reg, pending_next;
  logic                  pending_valid_reg, pending_valid_next;
  logic                  update_reg, update_next;
  logic                  overflow_reg, overflow_next;
  logic [7*DIGITS-1:0]   hex_reg, hex_next;
`ifdef DISPLAY_SIGNED_EN
  logic                  neg_reg, neg_next;
`endif

  logic                  start;
  logic [WIDTH-1:0]      start_val;
  logic [BCD_W-1:0]      bcd_adj;
  logic [BCD_DIGITS-1:0] digit_nz;
  logic [3:0]            msd;
  logic                  disp_ovf;
  logic [7*DIGITS-1:0]   disp_hex;

  // The top BCD bit is shifted out; it is always zero for WIDTH <= 32.
  logic unused_bcd_top;
  assign unused_bcd_top = bcd_adj[BCD_W-1];

  // Add-3 correction and nonzero flag for every BCD digit.
  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_bcd
      logic [3:0] digit;
      assign digit                = bcd_reg[4*gi +: 4];
      assign bcd_adj[4*gi +: 4]   = (digit >= 4'd5) ? digit + 4'd3 : digit;
      assign digit_nz[gi]         = |digit;
    end
  endgenerate

  // Locate the most significant nonzero digit (0 when the value is zero).
  always_comb begin
    msd = 4'd0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (digit_nz[i]) msd = 4'(i);
    end
  end

  // Overflow when significant digits (plus a sign) exceed the display width.
  always_comb begin
    disp_ovf = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (i >= DIGITS && digit_nz[i]) disp_ovf = 1'b1;
    end
`ifdef DISPLAY_SIGNED_EN
    if (neg_reg && (int'(msd) + 1 >= DIGITS)) disp_ovf = 1'b1;
`endif
  end

  // Per-digit segment selection: minus on overflow, blanking left of msd.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
      logic [6:0] seg;
      always_comb begin
        if (disp_ovf) begin
          seg = SEG_MINUS;
        end else if (4'(gi) <= msd) begin
          seg = seg_encode(bcd_reg[4*gi +: 4]);
`ifdef DISPLAY_SIGNED_EN
        end else if (neg_reg && (4'(gi) == msd + 4'd1)) begin
          seg = SEG_MINUS;
`endif
        end else begin
          seg = SEG_BLANK;
        end
      end
      assign disp_hex[7*gi +: 7] = seg;
    end
  endgenerate

  // Next-state logic: conversion sequencing, commit and pending buffer.
  always_comb begin
    state_next         = state_reg;
    shift_next         = shift_reg;
    bcd_next           = bcd_reg;
    count_next         = count_reg;
    pending_next       = pending_reg;
    pending_valid_next = pending_valid_reg;
    update_next        = 1'b0;
    overflow_next      = overflow_reg;
    hex_next           = hex_reg;
    start              = 1'b0;
    start_val          = data_in;
`ifdef DISPLAY_SIGNED_EN
    neg_next           = neg_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (pending_valid_reg) begin
          start              = 1'b1;
          start_val          = pending_reg;
          pending_valid_next = 1'b0;
        end else if (load) begin
          start = 1'b1;
        end
      end
`ifdef DISPLAY_SIGNED_EN
      NEGATE: begin
        if (neg_reg) shift_next = -shift_reg;
        state_next = CONVERT;
      end
`endif
      CONVERT: begin
        bcd_next   = {bcd_adj[BCD_W-2:0], shift_reg[WIDTH-1]};
        shift_next = {shift_reg[WIDTH-2:0], 1'b0};
        count_next = count_reg + 1'b1;
        if (count_reg == CW'(WIDTH - 1)) state_next = COMMIT;
      end
      COMMIT: begin
        hex_next      = disp_hex;
        overflow_next = disp_ovf;
        update_next   = 1'b1;
        if (pending_valid_reg) begin
          start              = 1'b1;
          start_val          = pending_reg;
          pending_valid_next = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (start) begin
      shift_next = start_val;
      bcd_next   = '0;
      count_next = '0;
`ifdef DISPLAY_SIGNED_EN
      neg_next   = start_val[WIDTH-1];
      state_next = NEGATE;
`else
      state_next = CONVERT;
`endif
    end

    // A load that does not start a conversion lands in the pending buffer.
    if (load && !(state_reg == IDLE && !pending_valid_reg)) begin
      pending_next       = data_in;
      pending_valid_next = 1'b1;
    end
  end

  // State register with synchronous reset to the "0" display.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= IDLE;
      shift_reg         <= '0;
      bcd_reg           <= '0;
      count_reg         <= '0;
      pending_reg       <= '0;
      pending_valid_reg <= 1'b0;
      update_reg        <= 1'b0;
      overflow_reg      <= 1'b0;
      hex_reg           <= HEX_RESET;
`ifdef DISPLAY_SIGNED_EN
      neg_reg           <= 1'b0;
`endif
    end else begin
      state_reg         <= state_next;
      shift_reg         <= shift_next;
      bcd_reg           <= bcd_next;
      count_reg         <= count_next;
      pending_reg       <= pending_next;
      pending_valid_reg <= pending_valid_next;
      update_reg        <= update_next;
      overflow_reg      <= overflow_next;
      hex_reg           <= hex_next;
`ifdef DISPLAY_SIGNED_EN
      neg_reg           <= neg_next;
`endif
    end
  end

  assign busy     = (state_reg != IDLE);
  assign update   = update_reg;
  assign overflow = overflow_reg;
  assign hex_out  = hex_reg;

endmodule

// File: tb/tb_output_display_driver.sv
// Testbench for output_display_driver: an event-timeline model of the
// display (decimal arithmetic on the loaded value) is compared against the
// DUT every cycle, plus literal expectations for the directed vectors.
module tb_output_display_driver;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 8;
`ifdef DISPLAY_SIGNED_EN
  localparam int LAT = WIDTH + 2;
`else
  localparam int LAT = WIDTH + 1;
`endif

  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] MI = 7'h3F;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                load  = 1'b0;
  logic [WIDTH-1:0]    data_in = '0;
  logic                busy, update, overflow;
  logic [7*DIGITS-1:0] hex_out;

  int checks = 0;
  int errors = 0;

  output_display_driver #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clock(clock), .reset(reset), .load(load), .data_in(data_in),
    .busy(busy), .update(update), .overflow(overflow), .hex_out(hex_out)
  );

  always #5 clock = ~clock;

  logic [6:0] seg_tab [10];
  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected display of a loaded value, computed with decimal arithmetic.
  function automatic logic [7*DIGITS-1:0] model_hex(input logic [WIDTH-1:0] v, output bit ovf);
    logic [7*DIGITS-1:0] h;
    longint unsigned mag, t, p;
    int n, need;
    bit neg;
    neg = 1'b0;
    mag = longint'(v);
`ifdef DISPLAY_SIGNED_EN
    neg = v[WIDTH-1];
    if (neg) mag = (longint'(1) << WIDTH) - longint'(v);
`endif
    n = 1;
    t = mag / 10;
    while (t != 0) begin
      n++;
      t = t / 10;
    end
    need = n + (neg ? 1 : 0);
    ovf  = (need > DIGITS);
    p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      if (ovf)                 h[7*k +: 7] = MI;
      else if (k < n)          h[7*k +: 7] = seg_tab[int'((mag / p) % 10)];
      else if (neg && k == n)  h[7*k +: 7] = MI;
      else                     h[7*k +: 7] = BL;
      p = p * 10;
    end
    return h;
  endfunction

  // Timeline model: a conversion started at edge c commits at edge c+LAT.
  bit                  m_valid = 0, m_active = 0, m_pend_v = 0;
  bit                  m_upd = 0, m_ovf = 0, m_busy = 0;
  logic [WIDTH-1:0]    m_val, m_pend;
  logic [7*DIGITS-1:0] m_hex;
  int                  cyc = 0, m_commit_at = 0;

  always @(posedge clock) begin
    bit taken, o;
    cyc++;
    if (reset) begin
      m_active = 0; m_pend_v = 0; m_upd = 0; m_ovf = 0; m_busy = 0;
      m_hex = model_hex('0, o);
      m_valid = 1;
    end else begin
      taken = 0;
      m_upd = 0;
      if (m_active && cyc == m_commit_at) begin
        m_hex = model_hex(m_val, o);
        m_ovf = o;
        m_upd = 1;
        m_active = 0;
        if (m_pend_v) begin
          m_active = 1; m_val = m_pend; m_commit_at = cyc + LAT; m_pend_v = 0;
        end
      end else if (!m_active) begin
        if (m_pend_v) begin
          m_active = 1; m_val = m_pend; m_commit_at = cyc + LAT; m_pend_v = 0;
        end else if (load) begin
          m_active = 1; m_val = data_in; m_commit_at = cyc + LAT; taken = 1;
        end
      end
      if (load && !taken) begin
        m_pend = data_in;
        m_pend_v = 1;
      end
      m_busy = m_active;
    end
  end

  // Compare process: every cycle once the model has seen a reset edge.
  always @(negedge clock) begin
    if (m_valid) begin
      check("busy", 128'(busy), 128'(m_busy));
      check("update", 128'(update), 128'(m_upd));
      check("overflow", 128'(overflow), 128'(m_ovf));
      check("hex_out", 128'(hex_out), 128'(m_hex));
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  // Strobe load for one edge, then scramble data_in (must be ignored).
  task automatic pulse_load(input logic [WIDTH-1:0] v);
    data_in = v;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    data_in = WIDTH'($urandom);
  endtask

  task automatic wait_update(input string name, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!update && n < 300);
    if (!update) begin
      checks++;
      errors++;
      $display("FAIL %s: no update pulse within %0d cycles", name, n);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    @(negedge clock);
    check("reset_hex", 128'(hex_out), 128'({{7{BL}}, 7'h40}));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_ovf", 128'(overflow), 128'(0));

    pulse_load(32'd1234);
    check("busy_after_load", 128'(busy), 128'(1));
    wait_update("upd_1234", n);
    check("latency_1234", 128'(n), 128'(LAT));
    check("hex_1234", 128'(hex_out), 128'({BL, BL, BL, BL, 7'h79, 7'h24, 7'h30, 7'h19}));

    pulse_load(32'd0);
    wait_update("upd_0", n);
    check("hex_0", 128'(hex_out), 128'({{7{BL}}, 7'h40}));

    pulse_load(32'd99999999);
    wait_update("upd_99999999", n);
    check("hex_99999999", 128'(hex_out), 128'({8{7'h10}}));
    check("ovf_99999999", 128'(overflow), 128'(0));

    pulse_load(32'd100000000);
    wait_update("upd_1e8", n);
    check("hex_1e8", 128'(hex_out), 128'({8{MI}}));
    check("ovf_1e8", 128'(overflow), 128'(1));
    idle(5);
    check("ovf_held", 128'(overflow), 128'(1));

    pulse_load(32'd5);
    wait_update("upd_5", n);
    check("ovf_5", 128'(overflow), 128'(0));
    check("hex_5", 128'(hex_out), 128'({{7{BL}}, 7'h12}));

    // Back-to-back loads: 10 at E0, 20 at E5, 30 at E10; 20 is overwritten.
    pulse_load(32'd10);
    idle(4);
    pulse_load(32'd20);
    idle(4);
    pulse_load(32'd30);
    wait_update("upd_10", n);
    check("latency_10", 128'(n), 128'(LAT - 10));
    check("hex_10", 128'(hex_out), 128'({{6{BL}}, 7'h79, 7'h40}));
    wait_update("upd_30", n);
    check("chain_30", 128'(n), 128'(LAT));
    check("hex_30", 128'(hex_out), 128'({{6{BL}}, 7'h30, 7'h40}));
    idle(2);
    check("idle_after_chain", 128'(busy), 128'(0));

    // Reset at E15 of a conversion of 777 aborts it.
    pulse_load(32'd777);
    idle(14);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_hex", 128'(hex_out), 128'({{7{BL}}, 7'h40}));
    check("abort_upd", 128'(update), 128'(0));
    idle(LAT + 5);

`ifdef DISPLAY_SIGNED_EN
    pulse_load(32'hFFFFFF85);
    wait_update("upd_m123", n);
    check("latency_m123", 128'(n), 128'(LAT));
    check("hex_m123", 128'(hex_out), 128'({BL, BL, BL, BL, MI, 7'h79, 7'h24, 7'h30}));
    pulse_load(32'h80000000);
    wait_update("upd_min", n);
    check("ovf_min", 128'(overflow), 128'(1));
`else
    pulse_load(32'hFFFFFFFF);
    wait_update("upd_max", n);
    check("ovf_max", 128'(overflow), 128'(1));
    pulse_load(32'd87654321);
    wait_update("upd_8digit", n);
    check("hex_8digit", 128'(hex_out),
          128'({7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79}));
`endif
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/output_display_driver.md
# output_display_driver

Sequential binary-to-decimal display driver sitting directly downstream of the processor's output memory: it captures the 32-bit word presented on that memory's data output whenever the output stage signals a new value, converts it to BCD with a shift-add-3 (double-dabble) engine, and drives a bank of active-low seven-segment digits. A one-deep pending buffer holds a value that arrives during a conversion, so back-to-back output instructions are not lost.

## Interface
- WIDTH, 32, bits of input value converted (legal 4..32)
- DIGITS, 8, seven-segment digits driven (legal 1..10)
- clock  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-high
- load  input  1  one-cycle strobe: data_in holds a new value to display
- data_in  input  WIDTH  value from the output memory's data port
- busy  output  1  high while a conversion is in progress
- update  output  1  one-cycle pulse when hex_out changes
- overflow  output  1  displayed value does not fit in DIGITS digits
- hex_out  output  7*DIGITS  digit k on bits [7k+6:7k], k=0 rightmost; bit order g..a, active-low

## Operation
- States: IDLE, CONVERT, COMMIT.
- IDLE: load=1 → capture data_in into shift register, clear 40-bit BCD register (10 digits), bit counter=0, go CONVERT.
- CONVERT: each cycle, every BCD digit ≥5 gets +3, then {bcd, shift} shifted left one bit; counter+1. After WIDTH shifts go COMMIT.
- COMMIT: overflow = any BCD digit at index ≥ DIGITS nonzero. Write hex_out, pulse update, then: pending valid → start conversion of pending value (go CONVERT, clear pending), else IDLE.
- Pending buffer: load while state≠IDLE writes data_in into pending and sets pending valid; a later load overwrites it (latest wins). load in COMMIT cycle also goes to pending.
- Encoding (active-low, gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111, minus=0111111.
- Leading-zero blanking: digits left of most significant nonzero digit blank; value 0 shows single "0" in digit 0.
- Overflow: every digit shows minus; overflow held until next COMMIT.

## Timing
- Reset: state IDLE, pending valid=0, busy=0, update=0, overflow=0, hex_out = all digits blank except digit 0 = "0" (display of value 0).
- load sampled at edge E0; CONVERT shifts on edges E1..EWIDTH; COMMIT at edge E(WIDTH+1) updates hex_out/overflow and asserts update for the following cycle. Latency WIDTH+1 edges (33 at WIDTH=32).
- busy = (state≠IDLE); high from cycle after E0 until COMMIT completes without pending.
- Chained pending conversion: next COMMIT exactly WIDTH+1 edges after previous COMMIT.
- reset mid-conversion aborts; pending discarded; outputs return to reset values next cycle.
- data_in only sampled on load edges; changes otherwise ignored.

## Configuration
- DISPLAY_SIGNED_EN defined: data_in treated as two's complement; negative values converted as magnitude (−2^(WIDTH−1) handled exactly); minus sign placed in digit immediately left of the leading displayed digit; overflow if sign plus digits exceeds DIGITS. Adds one cycle (magnitude negate) before CONVERT; latency WIDTH+2.
- Not defined: data_in unsigned; latency WIDTH+1; minus used only for overflow.

## Test plan
- reset, then load data_in=1234 → after 33 edges update pulses, hex_out digits 3..0 = 1,2,3,4, digits 7..4 blank, overflow=0.
- load 0 → digit 0 = 1000000, others 1111111; load 99999999 → all eight digits show 9, overflow=0.
- load 100000000 → all digits 0111111, overflow=1; then load 5 → overflow=0, digit 0 = 0010010.
- load 10, load 20 at E5, load 30 at E10 → update for 10 at E33, then 30 at E66; 20 never shown.
- reset at E15 of a conversion of 777 → busy=0, hex_out shows "0", no update pulse.
- DISPLAY_SIGNED_EN: load 32'hFFFFFF85 (−123) → digits 3..0 = minus,1,2,3 after 34 edges; load 32'h80000000 → overflow=1.
